// File: rtl/wave_capture_pkg.sv
// Shared types and defaults for the waveform capture scheduler.
package wave_capture_pkg;

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } capture_state_t;

  localparam int DEF_ADDR_W          = 8;
  localparam int DEF_DATA_W          = 8;
  localparam int DEF_TIMEOUT_SAMPLES = 1024;

endpackage

// File: rtl/wave_capture_arbiter_if.sv
// Display read bus plus the single-port sample RAM bus, as seen by the arbiter.
interface wave_capture_arbiter_if
  import wave_capture_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W:0]   ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    input  rd_req, rd_addr, ram_rdata,
    output rd_valid, rd_data, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    output rd_req, rd_addr, ram_rdata,
    input  rd_valid, rd_data, ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/ram_port_arbiter.sv
// Owns the RAM port: one-entry capture hold buffer, display-read priority,
// port mux and the read-valid pipeline.
module ram_port_arbiter
  import wave_capture_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  wave_capture_arbiter_if.master bus,
  input  logic                  i_read_half,
  input  logic [ADDR_W-1:0]     i_wr_idx,
  input  logic                  i_load,
  input  logic [DATA_W-1:0]     i_load_data,
  output logic                  o_hold_valid,
  output logic                  o_wr_issue
);

  logic              r_active;
  logic              r_hold_valid;
  logic [DATA_W-1:0] r_hold_data;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              w_rd_grant;
  logic              w_wr_issue;

  // r_active keeps the port silent while reset is asserted even if rd_req is high
  assign w_rd_grant = r_active & bus.rd_req;
  assign w_wr_issue = r_active & r_hold_valid & ~bus.rd_req;

  // Port mux: display read wins, pending capture write otherwise
  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = {(ADDR_W+1){1'b0}};
    bus.ram_wdata = {DATA_W{1'b0}};
    if (w_rd_grant) begin
      bus.ram_en   = 1'b1;
      bus.ram_addr = {i_read_half, bus.rd_addr};
    end else if (w_wr_issue) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = 1'b1;
      bus.ram_addr  = {~i_read_half, i_wr_idx};
      bus.ram_wdata = r_hold_data;
    end else begin
      bus.ram_en = 1'b0;
    end
  end

  // Hold buffer and read-return pipeline
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_active     <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_data  <= {DATA_W{1'b0}};
      r_rd_valid   <= 1'b0;
      r_rd_data    <= {DATA_W{1'b0}};
    end else begin
      r_active   <= 1'b1;
      r_rd_valid <= w_rd_grant;
      if (r_rd_valid) begin
        r_rd_data <= bus.ram_rdata;
      end
      // A load is accepted only if the slot is free or drains this cycle
      if (i_load && (!r_hold_valid || w_wr_issue)) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= i_load_data;
      end else if (w_wr_issue) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_valid ? bus.ram_rdata : r_rd_data;
  assign o_hold_valid = r_hold_valid;
  assign o_wr_issue   = w_wr_issue;

endmodule

// File: rtl/wave_capture_arbiter.sv
// Triggered capture of one frame of audio samples into the back half of a
// shared sample RAM, with half swap on vsync.
module wave_capture_arbiter
  import wave_capture_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int TIMEOUT_SAMPLES = DEF_TIMEOUT_SAMPLES
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_new_sample,
  input  logic [15:0]            i_sample,
  input  logic                   i_vsync,
  wave_capture_arbiter_if.master bus,
  output logic                   o_read_half,
  output logic [1:0]             o_capture_state,
  output logic                   o_overflow
);

  localparam int                TO_W     = $clog2(TIMEOUT_SAMPLES + 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = {ADDR_W{1'b1}};

  capture_state_t    r_state;
  logic              r_prev_neg;
  logic              r_vsync_d;
  logic              r_read_half;
  logic              r_overflow;
  logic [TO_W-1:0]   r_timeout_cnt;
  logic [ADDR_W-1:0] r_wr_idx;

  logic              w_vsync_rise;
  logic              w_fire;
  logic              w_last_write;
  logic              w_load;
  logic              w_drop;
  logic              w_hold_valid;
  logic              w_wr_issue;
  logic [DATA_W-1:0] w_conv;
  logic              w_unused_lsbs;

  // Signed sample to offset binary, keeping the top DATA_W bits
  assign w_conv        = {~i_sample[15], i_sample[14 -: DATA_W-1]};
  assign w_unused_lsbs = &{1'b0, i_sample[15-DATA_W:0]};

  assign w_vsync_rise = i_vsync & ~r_vsync_d;
  assign w_fire       = i_new_sample && (r_state == ST_ARMED) &&
                        ((r_prev_neg && !i_sample[15]) || (r_timeout_cnt == TO_LAST));
  assign w_last_write = w_wr_issue && (r_wr_idx == IDX_LAST);
  // A sample arriving alongside the frame's final write belongs to no frame
  assign w_load       = w_fire ||
                        (i_new_sample && (r_state == ST_CAPTURE) && !w_last_write);
  assign w_drop       = i_new_sample && (r_state == ST_CAPTURE) &&
                        w_hold_valid && !w_wr_issue;

  ram_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .bus          (bus),
    .i_read_half  (r_read_half),
    .i_wr_idx     (r_wr_idx),
    .i_load       (w_load),
    .i_load_data  (w_conv),
    .o_hold_valid (w_hold_valid),
    .o_wr_issue   (w_wr_issue)
  );

  // Capture FSM, trigger/timeout tracking and half swap
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_ARMED;
      r_prev_neg    <= 1'b0;
      r_vsync_d     <= 1'b0;
      r_read_half   <= 1'b0;
      r_overflow    <= 1'b0;
      r_timeout_cnt <= {TO_W{1'b0}};
      r_wr_idx      <= {ADDR_W{1'b0}};
    end else begin
      r_vsync_d <= i_vsync;
      if (i_new_sample) begin
        r_prev_neg <= i_sample[15];
      end
      case (r_state)
        ST_ARMED: begin
          if (w_fire) begin
            r_state       <= ST_CAPTURE;
            r_wr_idx      <= {ADDR_W{1'b0}};
            r_timeout_cnt <= {TO_W{1'b0}};
          end else if (i_new_sample) begin
            r_timeout_cnt <= r_timeout_cnt + TO_W'(1);
          end
        end
        ST_CAPTURE: begin
          if (w_drop) begin
            r_overflow <= 1'b1;
          end
          if (w_wr_issue) begin
            r_wr_idx <= r_wr_idx + ADDR_W'(1);
            if (w_last_write) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (w_vsync_rise) begin
            r_read_half <= ~r_read_half;
            r_overflow  <= 1'b0;
            r_state     <= ST_ARMED;
          end
        end
        default: begin
          r_state <= ST_ARMED;
        end
      endcase
    end
  end

  assign o_read_half     = r_read_half;
  assign o_capture_state = r_state;
  assign o_overflow      = r_overflow;

endmodule

// File: tb/tb_wave_capture_arbiter.sv
// Directed bench for wave_capture_arbiter with a small RAM model and write log.
module tb_wave_capture_arbiter;
  import wave_capture_pkg::*;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        new_sample = 1'b0;
  logic [15:0] sample = 16'h0000;
  logic        vsync = 1'b0;
  logic        read_half;
  logic [1:0]  capture_state;
  logic        overflow;

  int checks = 0;
  int passes = 0;

  logic [DW-1:0]   mem [0:7];
  logic [AW+DW:0]  wq [$];

  wave_capture_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  wave_capture_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT_SAMPLES (TO)
  ) dut (
    .i_clk           (clk),
    .i_reset_n       (reset_n),
    .i_new_sample    (new_sample),
    .i_sample        (sample),
    .i_vsync         (vsync),
    .bus             (bus),
    .o_read_half     (read_half),
    .o_capture_state (capture_state),
    .o_overflow      (overflow)
  );

  always #5 clk = ~clk;

  // RAM with 1-cycle read latency; every write is logged as {addr, data}
  always @(posedge clk) begin
    if (!reset_n) begin
      bus.ram_rdata <= 8'h00;
    end else if (bus.ram_en) begin
      if (bus.ram_we) begin
        mem[bus.ram_addr] <= bus.ram_wdata;
        wq.push_back({bus.ram_addr, bus.ram_wdata});
      end else begin
        bus.ram_rdata <= mem[bus.ram_addr];
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] s);
    @(negedge clk);
    new_sample = 1'b1;
    sample = s;
    @(negedge clk);
    new_sample = 1'b0;
  endtask

  task automatic pulse_vsync();
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.rd_req = 1'b0;
    bus.rd_addr = 2'd0;
    reset_n = 1'b0;
    idle(3);
    checks++; if (capture_state !== 2'd0) $display("FAIL reset_state got %0d exp 0", capture_state); else passes++;
    checks++; if (read_half !== 1'b0) $display("FAIL reset_read_half got %b exp 0", read_half); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else passes++;
    checks++; if ({bus.ram_en, bus.ram_we} !== 2'b00) $display("FAIL reset_ram_en_we got %b exp 00", {bus.ram_en, bus.ram_we}); else passes++;
    checks++; if ({bus.ram_addr, bus.ram_wdata} !== 11'h000) $display("FAIL reset_ram_addr_wdata got %h exp 000", {bus.ram_addr, bus.ram_wdata}); else passes++;
    checks++; if ({bus.rd_valid, bus.rd_data} !== 9'h000) $display("FAIL reset_rd got %h exp 000", {bus.rd_valid, bus.rd_data}); else passes++;
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_capture();
    logic [10:0] exp_w [4];
    logic [10:0] got;
    exp_w = '{11'h481, 11'h582, 11'h683, 11'h784};
    wq.delete();
    send(16'hFF00);
    send(16'h0100);
    // Write must not land in the cycle its sample arrives
    @(negedge clk);
    new_sample = 1'b1;
    sample = 16'h0200;
    #1;
    checks++; if (bus.ram_we !== 1'b0) $display("FAIL same_cycle_write got we=%b exp 0", bus.ram_we); else passes++;
    @(negedge clk);
    new_sample = 1'b0;
    send(16'h0300);
    send(16'h0400);
    idle(2);
    checks++; if (wq.size() !== 4) $display("FAIL capture_write_count got %0d exp 4", wq.size()); else passes++;
    for (int i = 0; i < 4; i++) begin
      got = (wq.size() > i) ? wq[i] : 11'hxxx;
      checks++; if (got !== exp_w[i]) $display("FAIL capture_write%0d got %h exp %h", i, got, exp_w[i]); else passes++;
    end
    checks++; if (capture_state !== 2'd2) $display("FAIL capture_done_state got %0d exp 2", capture_state); else passes++;
    send(16'h0500);
    idle(1);
    checks++; if (wq.size() !== 4 || overflow !== 1'b0) $display("FAIL done_ignores_sample got writes=%0d ovf=%b exp 4 0", wq.size(), overflow); else passes++;
    pulse_vsync();
    checks++; if (read_half !== 1'b1) $display("FAIL swap_read_half got %b exp 1", read_half); else passes++;
    checks++; if (capture_state !== 2'd0) $display("FAIL swap_state got %0d exp 0", capture_state); else passes++;
  endtask

  task automatic test_overflow();
    logic [10:0] exp_w [4];
    logic [10:0] got;
    exp_w = '{11'h090, 11'h1C0, 11'h2D0, 11'h3E0};
    wq.delete();
    send(16'h8000);
    @(negedge clk);
    bus.rd_req = 1'b1;
    bus.rd_addr = 2'd0;
    send(16'h1000);
    send(16'h2000);
    send(16'h3000);
    checks++; if (overflow !== 1'b1) $display("FAIL overflow_set got %b exp 1", overflow); else passes++;
    checks++; if (wq.size() !== 0) $display("FAIL read_blocks_write got %0d exp 0", wq.size()); else passes++;
    checks++; if (capture_state !== 2'd1) $display("FAIL overflow_state got %0d exp 1", capture_state); else passes++;
    @(negedge clk);
    bus.rd_req = 1'b0;
    #1;
    checks++; if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {2'b11, 3'd0, 8'h90}) $display("FAIL held_write_port got %b%b %h %h exp 11 0 90", bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata); else passes++;
    send(16'h4000);
    send(16'h5000);
    send(16'h6000);
    idle(2);
    for (int i = 0; i < 4; i++) begin
      got = (wq.size() > i) ? wq[i] : 11'hxxx;
      checks++; if (got !== exp_w[i]) $display("FAIL overflow_write%0d got %h exp %h", i, got, exp_w[i]); else passes++;
    end
    checks++; if (overflow !== 1'b1 || capture_state !== 2'd2) $display("FAIL overflow_sticky got ovf=%b st=%0d exp 1 2", overflow, capture_state); else passes++;
    pulse_vsync();
    checks++; if ({read_half, overflow, capture_state} !== 4'b0000) $display("FAIL overflow_clear got %b exp 0000", {read_half, overflow, capture_state}); else passes++;
  endtask

  task automatic test_timeout();
    wq.delete();
    for (int i = 0; i < 7; i++) send(16'h0100);
    checks++; if (capture_state !== 2'd0) $display("FAIL timeout_early got %0d exp 0", capture_state); else passes++;
    send(16'h0100);
    idle(1);
    checks++; if (capture_state !== 2'd1) $display("FAIL timeout_fire got %0d exp 1", capture_state); else passes++;
    checks++; if (wq.size() !== 1 || wq[0] !== 11'h481) $display("FAIL timeout_write got n=%0d w=%h exp 1 481", wq.size(), (wq.size() > 0) ? wq[0] : 11'h000); else passes++;
  endtask

  task automatic test_vsync_in_capture();
    logic [10:0] exp_w [3];
    logic [10:0] got;
    exp_w = '{11'h58A, 11'h68B, 11'h78C};
    wq.delete();
    pulse_vsync();
    checks++; if (read_half !== 1'b0 || capture_state !== 2'd1) $display("FAIL vsync_in_capture got rh=%b st=%0d exp 0 1", read_half, capture_state); else passes++;
    send(16'h0A00);
    send(16'h0B00);
    send(16'h0C00);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      got = (wq.size() > i) ? wq[i] : 11'hxxx;
      checks++; if (got !== exp_w[i]) $display("FAIL vsync_capture_write%0d got %h exp %h", i, got, exp_w[i]); else passes++;
    end
    pulse_vsync();
    checks++; if (read_half !== 1'b1 || capture_state !== 2'd0) $display("FAIL vsync_swap2 got rh=%b st=%0d exp 1 0", read_half, capture_state); else passes++;
  endtask

  task automatic test_read();
    @(negedge clk);
    bus.rd_req = 1'b1;
    bus.rd_addr = 2'd2;
    #1;
    checks++; if ({bus.ram_en, bus.ram_we, bus.ram_addr} !== {2'b10, 3'd6}) $display("FAIL read_port got %b%b %0d exp 10 6", bus.ram_en, bus.ram_we, bus.ram_addr); else passes++;
    @(negedge clk);
    bus.rd_req = 1'b0;
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h8B) $display("FAIL read_return got v=%b d=%h exp 1 8b", bus.rd_valid, bus.rd_data); else passes++;
    @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h8B) $display("FAIL read_hold got v=%b d=%h exp 0 8b", bus.rd_valid, bus.rd_data); else passes++;
  endtask

  task automatic test_reset_mid_capture();
    wq.delete();
    send(16'h8000);
    @(negedge clk);
    bus.rd_req = 1'b1;
    bus.rd_addr = 2'd1;
    send(16'h0100);
    checks++; if (capture_state !== 2'd1) $display("FAIL mid_capture_state got %0d exp 1", capture_state); else passes++;
    reset_n = 1'b0;
    #1;
    checks++; if ({read_half, capture_state, overflow} !== 4'b0000) $display("FAIL mid_reset_status got %b exp 0000", {read_half, capture_state, overflow}); else passes++;
    checks++; if ({bus.ram_en, bus.ram_we, bus.rd_valid} !== 3'b000) $display("FAIL mid_reset_port got %b exp 000", {bus.ram_en, bus.ram_we, bus.rd_valid}); else passes++;
    @(negedge clk);
    reset_n = 1'b1;
    bus.rd_req = 1'b0;
    idle(4);
    checks++; if (wq.size() !== 0) $display("FAIL partial_frame_discarded got %0d writes exp 0", wq.size()); else passes++;
    checks++; if (capture_state !== 2'd0) $display("FAIL post_reset_state got %0d exp 0", capture_state); else passes++;
  endtask

  initial begin
    bus.rd_req = 1'b0;
    bus.rd_addr = 2'd0;
    test_reset();
    test_capture();
    test_overflow();
    test_timeout();
    test_vsync_in_capture();
    test_read();
    test_reset_mid_capture();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
